// File: rtl/oehb_fifo_pkg.sv
// Shared sizing helpers for the opaque elastic buffer and its controller.
package oehb_fifo_pkg;

    // Slot pointers keep at least one bit so a single-slot buffer still has an address.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/oehb_fifo_ctrl.sv
// Dataless control for the opaque elastic buffer: pointers, occupancy and handshake.
module oehb_fifo_ctrl
    import oehb_fifo_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 2,
    parameter bit          READY_PASS = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ins_valid,
    input  logic                                outs_ready,
    output logic                                ins_ready,
    output logic                                outs_valid,
    output logic                                wr_en_c,
    output logic [ptr_width(NUM_SLOTS)-1:0]     wr_addr,
    output logic [ptr_width(NUM_SLOTS)-1:0]     rd_addr,
    output logic [cnt_width(NUM_SLOTS)-1:0]     count
);

    localparam int unsigned     PW       = ptr_width(NUM_SLOTS);
    localparam int unsigned     CW       = cnt_width(NUM_SLOTS);
    localparam logic [PW-1:0]   LAST     = PW'(NUM_SLOTS - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(NUM_SLOTS);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Wrap explicitly so non-power-of-two depths cycle through exactly NUM_SLOTS entries.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign outs_valid = ~empty;
    assign ins_ready  = READY_PASS ? (~full | outs_ready) : ~full;
    assign push       = ins_valid & ins_ready;
    assign pop        = outs_valid & outs_ready;
    assign wr_en_c    = push & ~rst;
    assign wr_addr    = tail;
    assign rd_addr    = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
    a_push_legal:  assert property (@(posedge clk) disable iff (rst) !(wr_en_c && !ins_ready));

endmodule

// File: rtl/oehb_fifo.sv
// Multi-slot, output-registered elastic buffer: controller plus slot storage and read mux.
module oehb_fifo
    import oehb_fifo_pkg::*;
#(
    parameter int unsigned DATA_TYPE  = 32,
    parameter int unsigned NUM_SLOTS  = 2,
    parameter bit          READY_PASS = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_TYPE-1:0]            ins,
    input  logic                            ins_valid,
    output logic                            ins_ready,
    output logic [DATA_TYPE-1:0]            outs,
    output logic                            outs_valid,
    input  logic                            outs_ready,
    output logic [cnt_width(NUM_SLOTS)-1:0] count
);

    localparam int unsigned PW = ptr_width(NUM_SLOTS);

    logic                 wr_en_c;
    logic [PW-1:0]        wr_addr;
    logic [PW-1:0]        rd_addr;
    logic [DATA_TYPE-1:0] mem [NUM_SLOTS];

    oehb_fifo_ctrl #(
        .NUM_SLOTS  (NUM_SLOTS),
        .READY_PASS (READY_PASS)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .outs_ready (outs_ready),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .wr_en_c    (wr_en_c),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .count      (count)
    );

    // Storage is left unreset; the controller guarantees no slot is read before it is written.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_addr] <= ins;
    end

    assign outs = mem[rd_addr];

endmodule

// File: doc/oehb_fifo.md
Name: oehb_fifo

Overview:
- Opaque (output-registered) elastic buffer carrying data, with a parametrised number of slots.
- It is the multi-slot, data-carrying successor of the single-slot dataless output elastic buffer. It breaks the combinational valid/data path between producer and consumer.
- It absorbs up to NUM_SLOTS tokens of backpressure.
- It is inserted on handshake channels by the buffer-placement pass wherever a valid path must be cut and slack added.

Parameters:
- DATA_TYPE, 32, data width in bits; must be >= 1.
- NUM_SLOTS, 2, storage depth in tokens; must be >= 1.
- READY_PASS, 1, value 1: when full, ins_ready = outs_ready (full throughput); value 0: ins_ready = not full (ready path fully cut, one bubble when full).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- ins  input  DATA_TYPE  input channel data.
- ins_valid  input  1  input channel valid.
- ins_ready  output  1  input channel ready.
- outs  output  DATA_TYPE  output channel data, taken from the head slot.
- outs_valid  output  1  output channel valid; registered.
- outs_ready  input  1  output channel ready.
- count  output  clog2(NUM_SLOTS+1)  current occupancy, for debug and verification.

Behaviour:
- Handshake rules:
  - push = ins_valid & ins_ready; pop = outs_valid & outs_ready.
  - Transfer happens only on the cycle where valid and ready are both high.
  - Standard elastic protocol: once outs_valid rises, outs_valid stays high and outs stays stable until pop. The block must never withdraw outs_valid while count > 0.
- Valid and data paths:
  - outs_valid = (count != 0), driven from registered state only. There is no combinational path from ins_valid or ins to outs_valid or outs.
  - Latency: a token pushed in cycle N is visible at outs, with outs_valid = 1, in cycle N+1 at the earliest.
- Ready path:
  - full = (count == NUM_SLOTS).
  - READY_PASS=1: ins_ready = ~full | outs_ready.
  - READY_PASS=0: ins_ready = ~full.
  - ins_ready never depends on ins_valid.
- State:
  - Circular storage of NUM_SLOTS entries, with a head (read) pointer, a tail (write) pointer and count.
  - Pointers are clog2(NUM_SLOTS) bits wide (1 bit minimum) and wrap from NUM_SLOTS-1 to 0; non-power-of-2 depths are supported.
- Per-edge updates:
  - push only: mem[tail] <= ins; tail advances; count +1.
  - pop only: head advances; count -1.
  - push & pop together: write, tail advance and head advance all occur; count is unchanged. This is legal when full only with READY_PASS=1, and the written slot is the one being freed.
  - Neither: hold all state.
- Empty: outs_valid=0 and no pop is possible; outs is don't-care.
- Full:
  - READY_PASS=0: ins_ready=0, no push.
  - READY_PASS=1: push is allowed only in the same cycle as a pop.
- Degenerate case: NUM_SLOTS=1 with READY_PASS=1 is cycle-equivalent to a single-slot data output elastic buffer, i.e. the next valid = ins_valid | (~outs_ready & valid).
- Reset:
  - On the edge where rst=1: count, head and tail go to 0; next-cycle outs_valid=0, count=0, and ins_ready=1.
  - Storage contents are not reset; outs is don't-care while outs_valid=0.
  - Reset asserted mid-operation discards all stored tokens; handshakes in that cycle are ignored.
- Assertions for verification: count never exceeds NUM_SLOTS; no push when ins_ready=0.

Decomposition:
- Shared package:
  - pointer-width function ptr_width(n) = max(1, clog2(n));
  - count-width function clog2(n+1).
- Sub-module oehb_fifo_ctrl (dataless):
  - owns head, tail, count, full and empty, and computes ins_ready, outs_valid, write enable, write address and read address;
  - parameters NUM_SLOTS and READY_PASS.
- The top level instantiates oehb_fifo_ctrl plus the DATA_TYPE x NUM_SLOTS register array and the read mux.

Test Plan:
- Reset then idle: rst held for 2 cycles, then ins_valid=0 -> outs_valid=0, count=0, ins_ready=1 every cycle.
- Latency, NUM_SLOTS=2: push 0xA5 in cycle 0 with outs_ready=1 -> cycle 1 outs=0xA5, outs_valid=1; cycle 2 outs_valid=0.
- Fill and backpressure, NUM_SLOTS=3, READY_PASS=0:
  - stimulus: outs_ready=0, push 1, 2, 3, then offer 4.
  - response: count reaches 3 and ins_ready=0 while full; 4 is held off.
  - release: raising outs_ready drains 1, 2, 3, then 4, in order.
- Full-throughput pass, NUM_SLOTS=2, READY_PASS=1:
  - stimulus: fill with 10, 11, then stream 12..20 with outs_ready=1 and ins_valid=1.
  - response: ins_ready=1 every cycle, count stays 2, and the output sequence is 10..20 with no bubbles.
- Wrap-around, NUM_SLOTS=3: push/pop 7 tokens 0x01..0x07 with random outs_ready -> in-order delivery and pointer wrap twice without loss or duplication.
- Reset mid-operation, NUM_SLOTS=4:
  - stimulus: count=3 holding 5, 6, 7; assert rst for 1 cycle while outs_ready=1.
  - response: next cycle count=0, outs_valid=0.
  - follow-up: a push of 9 then emerges as the first token.
